// File: rtl/uart_tx_queue.sv
// Circular byte FIFO feeding a UART transmitter: one launch pulse per byte, paced on done_tx.
// Optional sticky overflow flag enabled by defining UART_TXQ_OVERFLOW_EN.
module uart_tx_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_active,
    input  logic              done_tx,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                wr_acc;
    logic                pop;
    logic [CNT_W-1:0]    count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pop happens only on the IDLE->LAUNCH transition.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_active) begin
                    state_next = LAUNCH;
                    pop        = 1'b1;
                end
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (done_tx) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // full is the pre-edge flag, so a write in a full cycle is dropped even alongside a pop.
    always_comb begin
        wr_acc     = wr_en && !full;
        count_next = count + CNT_W'(wr_acc) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                tx_data <= mem[rd_ptr];
            end
            count    <= count_next;
            full     <= (count_next == CNT_W'(DEPTH));
            empty    <= (count_next == '0);
            tx_start <= pop;
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a simple done_tx responder.
module tb_uart_tx_queue;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic        done_tx;
    logic        overflow;
    logic        ovf_clr;

    logic        man_done;
    logic        auto_done;
    logic        auto_tx;
    int          launches;
    logic [7:0]  launched [$];
    int          passed;
    int          total;

    assign done_tx = man_done | auto_done;

    uart_tx_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .done_tx   (done_tx),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every launched byte, sampled mid-cycle.
    initial begin
        launches = 0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                launches = launches + 1;
                launched.push_back(tx_data);
            end
        end
    end

    // Transmitter stand-in: end-of-frame pulse about 20 cycles after each launch.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_tx && tx_start) begin
                repeat (20) @(posedge clk);
                #1 auto_done = 1'b1;
                @(posedge clk);
                #1 auto_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int base_n;
        int base_q;
        int guard;
        int wi;
        logic exp_ovf;

        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        tx_active = 1'b0;
        man_done  = 1'b0;
        auto_tx   = 1'b0;
        ovf_clr   = 1'b0;
`ifdef UART_TXQ_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif

        // Reset values
        repeat (3) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte latency
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("lat_count1", 32'(count), 32'd1);
        check("lat_nostart", 32'(tx_start), 32'd0);
        tick();
        check("lat_start", 32'(tx_start), 32'd1);
        check("lat_data", 32'(tx_data), 32'hA5);
        check("lat_count0", 32'(count), 32'd0);
        check("lat_empty", 32'(empty), 32'd1);
        tick();
        check("lat_start_one_cycle", 32'(tx_start), 32'd0);
        man_done = 1'b1; tick(); man_done = 1'b0;
        tick();

        // Burst fill with transmitter busy, then overflow
        tx_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("burst_full", 32'(full), 32'd1);
        check("burst_count", 32'(count), 32'd16);
        check("burst_empty", 32'(empty), 32'd0);
        wr_en = 1'b1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'(exp_ovf));
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Drain in order
        base_n = launches;
        base_q = launched.size();
        tx_active = 1'b0;
        auto_tx = 1'b1;
        guard = 0;
        while ((launches - base_n) < 16 && guard < 1000) begin
            tick();
            guard++;
        end
        repeat (25) tick();
        auto_tx = 1'b0;
        check("drain_launches", 32'(launches - base_n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base_q + i < launched.size())
                check("drain_order", 32'(launched[base_q + i]), 32'(i));
            else
                check("drain_missing", 32'(launched.size()), 32'(base_q + 16));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Hold-off while transmitter busy
        tx_active = 1'b1;
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        base_n = launches;
        repeat (50) tick();
        check("busy_no_launch", 32'(launches - base_n), 32'd0);
        check("busy_count", 32'(count), 32'd1);
        tx_active = 1'b0;
        tick();
        check("busy_release_start", 32'(tx_start), 32'd1);
        check("busy_release_data", 32'(tx_data), 32'h3C);
        tick();
        man_done = 1'b1; tick(); man_done = 1'b0;
        tick();

        // Simultaneous write and pop at count 3
        tx_active = 1'b1;
        wr_en = 1'b1; wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        check("simul_pre_count", 32'(count), 32'd3);
        tx_active = 1'b0;
        wr_en = 1'b1; wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        check("simul_count", 32'(count), 32'd3);
        check("simul_start", 32'(tx_start), 32'd1);
        check("simul_data", 32'(tx_data), 32'h11);
        tick();

        // Wrap: remaining 22,33,44 then 40 more bytes through the queue
        base_n = launches;
        base_q = launched.size();
        man_done = 1'b1; tick(); man_done = 1'b0;
        auto_tx = 1'b1;
        wi = 0;
        guard = 0;
        while (wi < 40 && guard < 5000) begin
            if (!full) begin
                wr_en = 1'b1; wr_data = 8'(8'h80 + wi);
                wi++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            guard++;
        end
        wr_en = 1'b0;
        guard = 0;
        while ((launches - base_n) < 43 && guard < 2000) begin
            tick();
            guard++;
        end
        repeat (25) tick();
        auto_tx = 1'b0;
        check("wrap_launches", 32'(launches - base_n), 32'd43);
        for (int i = 0; i < 43; i++) begin
            logic [7:0] exp_b;
            if (i == 0) exp_b = 8'h22;
            else if (i == 1) exp_b = 8'h33;
            else if (i == 2) exp_b = 8'h44;
            else exp_b = 8'(8'h80 + (i - 3));
            if (base_q + i < launched.size())
                check("wrap_order", 32'(launched[base_q + i]), 32'(exp_b));
            else
                check("wrap_missing", 32'(launched.size()), 32'(base_q + 43));
        end

        // Reset during WAIT with five bytes queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        check("mid_pre_count", 32'(count), 32'd5);
        rst = 1'b1;
        tick();
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_tx_start", 32'(tx_start), 32'd0);
        check("mid_full", 32'(full), 32'd0);
        rst = 1'b0;
        base_n = launches;
        repeat (30) tick();
        check("mid_no_launch", 32'(launches - base_n), 32'd0);
        check("mid_count_after", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
